// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential radix-2 shift-and-add multiplier
//
// Produces a 2*WIDTH-bit product from two WIDTH-bit operands, one partial
// product bit per clock, with optional two's-complement signed operation.
//
// Ports:
//   clk          in   1        rising-edge clock
//   rst          in   1        asynchronous, active-low reset
//   start        in   1        request a multiply (sampled only in IDLE)
//   signed_mode  in   1        1 = signed operands, 0 = unsigned (sampled with start)
//   multiplicand in   WIDTH    operand A (sampled with start)
//   multiplier   in   WIDTH    operand B (sampled with start)
//   product      out  2*WIDTH  registered result, held until the next completion
//   busy         out  1        operation in progress (state != IDLE)
//   valid        out  1        one-cycle pulse when product has just been updated

module shift_add_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               valid
);

  // One spare bit so the counter can hold WIDTH-1 for any legal WIDTH.
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MULTIPLY = 2'd1,
    FINISH   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;          // {upper, lower}; lower starts as |B|
  logic [WIDTH-1:0]   a_q, a_d;              // |A|
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               valid_q, valid_d;

  // Operand magnitudes. The most-negative value negates to itself, which read
  // as unsigned is exactly 2^(WIDTH-1), so no extra bit is needed.
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;

  // Partial-product add kept WIDTH+1 wide so the carry shifts into the MSB.
  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   shifted;

  always_comb begin
    a_neg = signed_mode & multiplicand[WIDTH-1];
    b_neg = signed_mode & multiplier[WIDTH-1];
    a_abs = a_neg ? (~multiplicand + WIDTH'(1)) : multiplicand;
    b_abs = b_neg ? (~multiplier + WIDTH'(1)) : multiplier;
  end

  always_comb begin
    sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    shifted = {sum, acc_q[WIDTH-1:0]};
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    a_d       = a_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    product_d = product_q;
    valid_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a_abs;
          acc_d   = {{WIDTH{1'b0}}, b_abs};
          neg_d   = a_neg ^ b_neg;
          cnt_d   = '0;
          state_d = MULTIPLY;
        end
      end

      MULTIPLY: begin
        acc_d = shifted[2*WIDTH:1];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FINISH;
        end
      end

      FINISH: begin
        // Negating zero yields zero, so no negative zero can appear.
        product_d = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
        valid_d   = 1'b1;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      a_q       <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      a_q       <= a_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      product_q <= product_d;
      valid_q   <= valid_d;
    end
  end

  assign product = product_q;
  assign valid   = valid_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - scoreboard bench for shift_add_multiplier

module tb_shift_add_multiplier;

  localparam int W   = 16;
  localparam int LAT = W + 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic           signed_mode = 1'b0;
  logic [W-1:0]   multiplicand = '0;
  logic [W-1:0]   multiplier = '0;
  logic [2*W-1:0] product;
  logic           busy;
  logic           valid;

  int total = 0;
  int bad   = 0;

  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] last_exp = '0;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .signed_mode  (signed_mode),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .busy         (busy),
    .valid        (valid)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sm);
    logic [63:0] pa, pb, p;
    pa = sm ? {{(64-W){a[W-1]}}, a} : {{(64-W){1'b0}}, a};
    pb = sm ? {{(64-W){b[W-1]}}, b} : {{(64-W){1'b0}}, b};
    p  = pa * pb;
    return p[2*W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
    multiplicand = a;
    multiplier   = b;
    signed_mode  = sm;
    start        = 1'b1;
    exp_q.push_back(model(a, b, sm));
  endtask

  // Counts edges from the sampling edge until valid, then pops the scoreboard.
  // With hold_check set, product must keep last_exp while waiting.
  task automatic wait_result(input string name, input bit hold_check);
    int lat;
    logic [2*W-1:0] e;
    lat = 0;
    while (lat < 40) begin
      tick();
      lat++;
      if (lat == 1) start = 1'b0;
      if (valid) break;
      if (hold_check) begin
        total++;
        if (product !== last_exp) begin
          bad++;
          $display("FAIL %s_hold: product=%h expected=%h at edge %0d", name, product, last_exp, lat);
        end
      end
    end
    total++;
    if (lat != LAT || !valid) begin
      bad++;
      $display("FAIL %s_latency: edges=%0d valid=%b expected edges=%0d", name, lat, valid, LAT);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_busy_in_valid: busy=%b expected=0", name, busy);
    end
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s_scoreboard: result with empty queue product=%h", name, product);
    end else begin
      e = exp_q.pop_front();
      last_exp = e;
      total++;
      if (product !== e) begin
        bad++;
        $display("FAIL %s_product: product=%h expected=%h", name, product, e);
      end
    end
  endtask

  task automatic test_reset();
    #3;
    total++;
    if (product !== '0 || valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: product=%h valid=%b busy=%b expected 0/0/0", product, valid, busy);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    tick();
    total++;
    if (product !== '0 || valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: product=%h valid=%b busy=%b expected 0/0/0", product, valid, busy);
    end
  endtask

  task automatic test_unsigned();
    drive_op(16'hFFFF, 16'hFFFF, 1'b0);
    wait_result("unsigned_max", 1'b0);
    total++;
    if (product !== 32'hFFFE0001) begin
      bad++;
      $display("FAIL unsigned_const: product=%h expected=fffe0001", product);
    end
    tick();
    total++;
    if (valid !== 1'b0) begin
      bad++;
      $display("FAIL valid_one_cycle: valid=%b expected=0", valid);
    end
  endtask

  task automatic test_signed();
    drive_op(16'hFFFD, 16'h0007, 1'b1);
    wait_result("signed_neg3x7", 1'b0);
    tick();
    drive_op(16'h8000, 16'h8000, 1'b1);
    wait_result("signed_minxmin", 1'b0);
    tick();
    drive_op(16'h8000, 16'h7FFF, 1'b1);
    wait_result("signed_minxmax", 1'b0);
    tick();
  endtask

  task automatic test_zero_identity();
    drive_op(16'h0000, 16'h1234, 1'b0);
    wait_result("zero_a", 1'b0);
    tick();
    drive_op(16'h0001, 16'h8000, 1'b0);
    wait_result("ident_unsigned", 1'b0);
    tick();
    drive_op(16'h0001, 16'h8000, 1'b1);
    wait_result("ident_signed", 1'b0);
    tick();
    drive_op(16'hFFFF, 16'h0000, 1'b1);
    wait_result("zero_signed", 1'b0);
    tick();
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic         sm;
    for (int i = 0; i < 6; i++) begin
      a  = W'($urandom);
      b  = W'($urandom);
      sm = 1'($urandom_range(0, 1));
      drive_op(a, b, sm);
      wait_result("random", 1'b0);
      tick();
    end
  endtask

  task automatic test_ignored_start();
    int vcnt, lat;
    logic [2*W-1:0] prev, e;
    prev = last_exp;
    vcnt = 0;
    lat  = 0;
    drive_op(16'h0123, 16'h0045, 1'b0);
    for (int i = 1; i <= 45; i++) begin
      tick();
      if (i == 1) start = 1'b0;
      if (i == 2 || i == 9) begin
        start        = 1'b1;
        multiplicand = 16'hAAAA;
        multiplier   = 16'h5555;
        signed_mode  = 1'b1;
      end
      if (i == 3 || i == 10) begin
        start = 1'b0;
        total++;
        if (product !== prev) begin
          bad++;
          $display("FAIL ignored_hold: product=%h expected=%h at edge %0d", product, prev, i);
        end
      end
      if (valid) begin
        vcnt++;
        if (vcnt == 1) begin
          lat = i;
          e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
          last_exp = e;
          total++;
          if (product !== e) begin
            bad++;
            $display("FAIL ignored_product: product=%h expected=%h", product, e);
          end
        end
      end
    end
    total++;
    if (vcnt != 1) begin
      bad++;
      $display("FAIL ignored_pulses: valid pulses=%0d expected=1", vcnt);
    end
    total++;
    if (lat != LAT) begin
      bad++;
      $display("FAIL ignored_latency: edges=%0d expected=%0d", lat, LAT);
    end
    total++;
    if (product !== last_exp) begin
      bad++;
      $display("FAIL ignored_final: product=%h expected=%h", product, last_exp);
    end
  endtask

  task automatic test_back_to_back();
    drive_op(16'h1234, 16'h5678, 1'b0);
    wait_result("b2b_first", 1'b0);
    // Still in the valid cycle: the new request must be accepted at the next edge.
    drive_op(16'hFEDC, 16'h0011, 1'b1);
    wait_result("b2b_second", 1'b1);
    tick();
  endtask

  task automatic test_reset_midop();
    int vcnt, bcnt;
    multiplicand = 16'h7777;
    multiplier   = 16'h3333;
    signed_mode  = 1'b0;
    start        = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (product !== '0 || valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_midop: product=%h valid=%b busy=%b expected 0/0/0", product, valid, busy);
    end
    @(negedge clk);
    rst = 1'b1;
    vcnt = 0;
    bcnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (valid) vcnt++;
      if (busy) bcnt++;
    end
    total++;
    if (vcnt != 0 || bcnt != 0) begin
      bad++;
      $display("FAIL reset_after: valid pulses=%0d busy cycles=%0d expected 0/0", vcnt, bcnt);
    end
    total++;
    if (product !== '0) begin
      bad++;
      $display("FAIL reset_product: product=%h expected=0", product);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d results never produced", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_zero_identity();
    test_random();
    test_ignored_start();
    test_back_to_back();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
